// File: rtl/mine_map_generator.sv
// mine_map_generator: places NUM_MINES distinct mines on the 8x8 board,
// never on SAFE_CELL, then loads the finished map into the datapath
// through the MMin/ldMM port and pulses done.
//
// state  | meaning
// IDLE   | waiting for start; LFSR free-running
// CLEAR  | zero the map accumulator and mine counter
// PLACE  | one candidate cell per cycle from lfsr[5:0]; retry on safe/occupied
// LOAD   | ldMM high, MMin holds the complete map
// DONE   | done high for one cycle, then back to IDLE
module mine_map_generator #(
  parameter int          NUM_MINES = 10,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SAFE_CELL = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        seed_ld,
  input  logic [15:0] seed_in,
  output logic        busy,
  output logic        ldMM,
  output logic [63:0] MMin,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_PLACE = 3'd2;
  localparam logic [2:0] S_LOAD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [5:0]  SAFE_IDX = 6'(SAFE_CELL);
  localparam logic [5:0]  MINES_6  = 6'(NUM_MINES);

  // Reject parameter values that cannot produce a legal board.
  if (NUM_MINES < 1 || NUM_MINES > 63) begin : g_bad_num_mines
    $error("mine_map_generator: NUM_MINES must be in 1..63");
  end
  if (SAFE_CELL < 0 || SAFE_CELL > 63) begin : g_bad_safe_cell
    $error("mine_map_generator: SAFE_CELL must be in 0..63");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("mine_map_generator: SEED must be nonzero");
  end

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] lfsr;
  logic [63:0] map_acc;
  logic [5:0]  mine_cnt;
  logic [5:0]  cand;
  logic        cand_ok;
  logic        last_mine;

  assign cand      = lfsr[5:0];
  assign cand_ok   = (cand != SAFE_IDX) && !map_acc[cand];
  assign last_mine = cand_ok && ((mine_cnt + 6'd1) == MINES_6);

  // LFSR shifts every cycle in every state; a seed load takes priority,
  // and a zero seed is replaced so the register can never lock up.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= SEED;
    end else if (seed_ld) begin
      lfsr <= (seed_in == 16'h0000) ? SEED : seed_in;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    end
  end

  // Next-state decode; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_PLACE;
      S_PLACE: if (last_mine) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Map accumulator and mine counter; the map is held after DONE until the next CLEAR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      map_acc  <= 64'h0;
      mine_cnt <= 6'd0;
    end else if (state == S_CLEAR) begin
      map_acc  <= 64'h0;
      mine_cnt <= 6'd0;
    end else if (state == S_PLACE && cand_ok) begin
      map_acc[cand] <= 1'b1;
      mine_cnt      <= mine_cnt + 6'd1;
    end
  end

  assign busy = (state != S_IDLE);
  assign ldMM = (state == S_LOAD);
  assign done = (state == S_DONE);
  assign MMin = map_acc;

endmodule

// File: doc/mine_map_generator.md
# mine_map_generator

Produces a random 64-cell mine map for the 8x8 board and loads it into the game datapath's mine-map register through its `MMin`/`ldMM` load port. On a `start` request it places exactly `NUM_MINES` distinct mines, never on the start cell. It then drives the finished map on `MMin`, pulses `ldMM` for one cycle, and signals `done`. It sits between the game control FSM, which issues `start`, and the datapath's mine-map load port.

## Interface
- `NUM_MINES`, default 10: number of mines placed. Legal range 1..63; values outside this range are a compile-time error.
- `SEED`, default 16'hACE1: LFSR reset value. Also substituted whenever a zero seed is loaded. Must be nonzero.
- `SAFE_CELL`, default 0: cell index (0..63) that never receives a mine. Matches the position map's reset position, bit 0.
- `clk  in  1`: clock, rising edge.
- `resetn  in  1`: reset, asynchronous, active-low.
- `start  in  1`: generation request, sampled in IDLE only.
- `seed_ld  in  1`: load `seed_in` into the LFSR this cycle.
- `seed_in  in  16`: seed value. Zero is replaced by `SEED`.
- `busy  out  1`: high in every state except IDLE.
- `ldMM  out  1`: one-cycle load strobe to the datapath.
- `MMin  out  64`: mine map, bit i = cell i (row i/8, col i%8).
- `done  out  1`: one-cycle completion pulse.

## Operation
- **LFSR**: 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1). It shifts every clk cycle in every state, so the time at which `start` arrives supplies entropy.
  - `seed_ld` overrides the shift that cycle.
  - `seed_ld` is legal in any state.
- **Internal registers**: map accumulator (64 bits), mine counter (6 bits).
- **`MMin`** is driven directly from the map accumulator.
- **FSM states**: IDLE, CLEAR, PLACE, LOAD, DONE.
  - **IDLE**: `start`=1 -> CLEAR. Otherwise stay.
  - **CLEAR**: accumulator <= 0, counter <= 0 -> PLACE.
  - **PLACE**: each cycle, candidate c = lfsr[5:0].
    - If c != `SAFE_CELL` and accumulator[c]==0: set the bit and increment the counter.
    - Otherwise the cycle is spent with no change (a retry).
    - When the counter reaches `NUM_MINES` (the cycle of the final placement) -> LOAD.
  - **LOAD**: `ldMM`=1 -> DONE.
  - **DONE**: `done`=1 -> IDLE.
- **Termination**: the LFSR period is 65535 and its low 6 bits cover all 64 values, so PLACE always terminates. No watchdog is required.
- `start` while `busy` is ignored. It is not queued.
- After DONE, the accumulator and `MMin` hold the last map unchanged until the next CLEAR.
- **Reset** (any time, including mid-PLACE):
  - state -> IDLE, accumulator = 0, counter = 0, lfsr = `SEED`.
  - `ldMM`, `done`, `busy` = 0.
  - A partially built map is never loaded.
- **Invariants**:
  - popcount(`MMin`) at `ldMM` == `NUM_MINES`.
  - `MMin[SAFE_CELL]` == 0 at all times.

## Timing
- **Reset values**: `busy`=0, `ldMM`=0, `done`=0, `MMin`=64'b0.
- **Latency**, with `start` sampled high at edge k:
  - CLEAR occupies cycle k..k+1.
  - PLACE starts at edge k+1.
  - `ldMM` is high in the cycle after the final placement.
  - `done` is high in the cycle after `ldMM`.
  - `busy` falls with the return to IDLE.
- Minimum start-to-`ldMM` latency = `NUM_MINES`+2 edges (no retries). Each retry adds one cycle.
- `MMin` is stable with the final map in the cycle `ldMM` is high and remains stable afterward. The datapath captures it on the same clk edge that ends LOAD.
- `ldMM` and `done` are each exactly one cycle wide and never overlap.
- `start` may be re-asserted in the cycle `done` is high. It is sampled in IDLE on the next edge, so back-to-back generations are separated by one IDLE cycle.

## Test plan
- **Reset**: assert `resetn`=0 mid-operation -> all outputs 0 asynchronously. After release, `busy`=0 and `MMin`=0.
- **Default generation**: `seed_ld`=1 with `seed_in`=16'h1234, then `start` pulse.
  - Expect exactly one `ldMM` pulse, with popcount(`MMin`)=10 and `MMin[0]`=0.
  - `done` follows one cycle later; `busy` stays high from start until return to IDLE.
  - The start-to-`ldMM` edge count is ≥12.
- **Saturation**: `NUM_MINES`=63, `SAFE_CELL`=0 -> `MMin`=64'hFFFF_FFFF_FFFF_FFFE at `ldMM`. Also run `SAFE_CELL`=27 -> bit 27 is the only zero bit.
- **Determinism**:
  - Two runs, each preceded by `seed_ld`=1 with the same `seed_in` and the same seed-to-start delay -> identical `MMin` and identical latency.
  - A different `seed_in` -> different map.
  - `seed_in`=0 -> behaviour identical to loading 16'hACE1.
- **Busy / reset abort**:
  - `start` pulsed every cycle during PLACE -> exactly one `ldMM` and one `done`.
  - `resetn` pulsed low mid-PLACE -> no `ldMM`, `MMin`=0, next `start` produces a full valid map.
- **Back-to-back**: `start` asserted during the `done` cycle -> second generation begins after one IDLE cycle. The second map satisfies the popcount and safe-cell invariants.
